// File: rtl/jtag_dbg_pkg.sv
// rtl/jtag_dbg_pkg.sv - shared constants, state type and jce priority encoder for the JTAG debug-register bridge
package jtag_dbg_pkg;

   localparam int JTAG_DBG_DW    = 32;
   localparam int JTAG_DBG_NCHAN = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } jtag_state_t;

   // Lowest set bit wins; callers zero-pad narrower enable vectors to 4 bits.
   function automatic logic [1:0] first_set_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/jtag_tck_sync.sv
// rtl/jtag_tck_sync.sv - synchroniser chain for jtck and JTAG sideband inputs with TCK edge detection
module jtag_tck_sync
   import jtag_dbg_pkg::*;
#(
   parameter int NCHAN       = JTAG_DBG_NCHAN,
   parameter int SYNC_STAGES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             jtck,
   input  logic             jtdi,
   input  logic             jshift,
   input  logic             jupdate,
   input  logic             jrstn,
   input  logic [NCHAN-1:0] jce,
   output logic             tdi_s,
   output logic             shift_s,
   output logic             update_s,
   output logic             rstn_s,
   output logic [NCHAN-1:0] jce_s,
   output logic             tck_rise,
   output logic             tck_fall
);

   localparam int BW = NCHAN + 5;

   logic [BW-1:0] stage_q [SYNC_STAGES];
   logic [BW-1:0] stage_d [SYNC_STAGES];
   logic          tck_prev_q, tck_prev_d;
   logic          tck_s;

   // Sidebands ride in the same chain as jtck so they arrive aligned with its edges.
   always_comb begin
      stage_d[0] = {jce, jrstn, jupdate, jshift, jtdi, jtck};
      for (int i = 1; i < SYNC_STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
      tck_prev_d = stage_q[SYNC_STAGES-1][0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= '0;
         end
         tck_prev_q <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_d[i];
         end
         tck_prev_q <= tck_prev_d;
      end
   end

   assign {jce_s, rstn_s, update_s, shift_s, tdi_s, tck_s} = stage_q[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_prev_q;
   assign tck_fall = ~tck_s & tck_prev_q;

endmodule

// File: rtl/jtag_dbgreg_bridge.sv
// rtl/jtag_dbgreg_bridge.sv - JTAGG user-DR to SoC debug-register bridge; JTAG_DBGREG_READBACK_EN enables capture readback on TDO
module jtag_dbgreg_bridge
   import jtag_dbg_pkg::*;
#(
   parameter int DW          = JTAG_DBG_DW,
   parameter int NCHAN       = JTAG_DBG_NCHAN,
   parameter int SYNC_STAGES = 3,
   parameter int SW          = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                jtck,
   input  logic                jtdi,
   input  logic                jshift,
   input  logic                jupdate,
   input  logic                jrstn,
   input  logic [NCHAN-1:0]    jce,
   output logic                jtdo,
   input  logic [NCHAN*DW-1:0] dbgreg_in,
   output logic [DW-1:0]       dbgreg_out,
   output logic [SW-1:0]       dbgreg_sel,
   output logic                dbgreg_strobe,
   output logic                err_len,
   input  logic                err_clr
);

   localparam int             CW       = $clog2(DW + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(DW);
   localparam logic [CW-1:0] CNT_SAT  = CW'(DW + 1);

   logic             tdi_s, shift_s, update_s, rstn_s, tck_rise, tck_fall;
   logic [NCHAN-1:0] jce_s;

   jtag_tck_sync #(
      .NCHAN       (NCHAN),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk      (clk),
      .rst      (rst),
      .jtck     (jtck),
      .jtdi     (jtdi),
      .jshift   (jshift),
      .jupdate  (jupdate),
      .jrstn    (jrstn),
      .jce      (jce),
      .tdi_s    (tdi_s),
      .shift_s  (shift_s),
      .update_s (update_s),
      .rstn_s   (rstn_s),
      .jce_s    (jce_s),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall)
   );

   jtag_state_t   state_q, state_d;
   logic [SW-1:0] cur_chan_q, cur_chan_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [CW-1:0] bitcnt_q, bitcnt_d;
   logic          jtdo_q, jtdo_d;
   logic [DW-1:0] dbgreg_out_q, dbgreg_out_d;
   logic [SW-1:0] dbgreg_sel_q, dbgreg_sel_d;
   logic          strobe_q, strobe_d;
   logic          err_len_q, err_len_d;
   logic          err_set;
   logic [1:0]    cap_idx;
   logic [DW-1:0] cap_val;
   logic          tdo_bit;

   assign cap_idx = first_set_index(4'(jce_s));

`ifdef JTAG_DBGREG_READBACK_EN
   always_comb begin
      cap_val = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (cap_idx == 2'(i)) cap_val = dbgreg_in[i*DW +: DW];
      end
   end
   assign tdo_bit = shreg_q[0];
`else
   logic unused_readback;
   assign unused_readback = ^dbgreg_in;
   assign cap_val = '0;
   assign tdo_bit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cur_chan_d   = cur_chan_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      jtdo_d       = jtdo_q;
      dbgreg_out_d = dbgreg_out_q;
      dbgreg_sel_d = dbgreg_sel_q;
      strobe_d     = 1'b0;
      err_set      = 1'b0;
      if (!rstn_s) begin
         state_d    = IDLE;
         cur_chan_d = '0;
         shreg_d    = '0;
         bitcnt_d   = '0;
         jtdo_d     = 1'b0;
      end else begin
         if (tck_rise) begin
            if (update_s) begin
               if (state_q == SHIFT) begin
                  if (bitcnt_q == CNT_FULL) begin
                     dbgreg_out_d = shreg_q;
                     dbgreg_sel_d = cur_chan_q;
                     strobe_d     = 1'b1;
                  end else begin
                     err_set = 1'b1;
                  end
                  state_d = IDLE;
               end
            end else if (|jce_s && !shift_s) begin
               state_d    = SHIFT;
               cur_chan_d = SW'(cap_idx);
               shreg_d    = cap_val;
               bitcnt_d   = '0;
            end else if (shift_s && state_q == SHIFT) begin
               shreg_d = {tdi_s, shreg_q[DW-1:1]};
               if (bitcnt_q != CNT_SAT) bitcnt_d = bitcnt_q + 1'b1;
            end
         end
         if (tck_fall) jtdo_d = tdo_bit;
      end
      // A fresh length error outranks a simultaneous clear.
      err_len_d = (err_len_q & ~err_clr) | err_set;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cur_chan_q   <= '0;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         jtdo_q       <= 1'b0;
         dbgreg_out_q <= '0;
         dbgreg_sel_q <= '0;
         strobe_q     <= 1'b0;
         err_len_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_chan_q   <= cur_chan_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         jtdo_q       <= jtdo_d;
         dbgreg_out_q <= dbgreg_out_d;
         dbgreg_sel_q <= dbgreg_sel_d;
         strobe_q     <= strobe_d;
         err_len_q    <= err_len_d;
      end
   end

   assign jtdo          = jtdo_q;
   assign dbgreg_out    = dbgreg_out_q;
   assign dbgreg_sel    = dbgreg_sel_q;
   assign dbgreg_strobe = strobe_q;
   assign err_len       = err_len_q;

endmodule

// File: tb/tb_jtag_dbgreg_bridge.sv
// tb/tb_jtag_dbgreg_bridge.sv - randomized self-checking bench for jtag_dbgreg_bridge with a transfer-level model
module tb_jtag_dbgreg_bridge;

   localparam int DW    = 32;
   localparam int NCHAN = 2;
   localparam int SW    = 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                jtck = 1'b0, jtdi = 1'b0, jshift = 1'b0, jupdate = 1'b0, jrstn = 1'b1;
   logic [NCHAN-1:0]    jce = '0;
   logic [NCHAN*DW-1:0] dbgreg_in = '0;
   logic                err_clr = 1'b0;
   logic                jtdo;
   logic [DW-1:0]       dbgreg_out;
   logic [SW-1:0]       dbgreg_sel;
   logic                dbgreg_strobe;
   logic                err_len;

   int            n_checks = 0;
   int            n_errors = 0;
   int            strobe_cnt = 0;
   logic [DW-1:0] last_out = '0;
   logic [SW-1:0] last_sel = '0;
   logic [DW-1:0] exp_out = '0;
   logic [SW-1:0] exp_sel = '0;
   logic          exp_err = 1'b0;

   always #5 clk = ~clk;

   jtag_dbgreg_bridge #(
      .DW          (DW),
      .NCHAN       (NCHAN),
      .SYNC_STAGES (3)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .jtck          (jtck),
      .jtdi          (jtdi),
      .jshift        (jshift),
      .jupdate       (jupdate),
      .jrstn         (jrstn),
      .jce           (jce),
      .jtdo          (jtdo),
      .dbgreg_in     (dbgreg_in),
      .dbgreg_out    (dbgreg_out),
      .dbgreg_sel    (dbgreg_sel),
      .dbgreg_strobe (dbgreg_strobe),
      .err_len       (err_len),
      .err_clr       (err_clr)
   );

   always @(negedge clk) begin
      if (dbgreg_strobe) begin
         strobe_cnt <= strobe_cnt + 1;
         last_out   <= dbgreg_out;
         last_sel   <= dbgreg_sel;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_tdo(input logic [31:0] rb);
`ifdef JTAG_DBGREG_READBACK_EN
      return rb;
`else
      return 32'h0;
`endif
   endfunction

   // One TCK period of 8 clk: TDO sampled just before the rising edge.
   task automatic tck_pulse(output logic tdo_s);
      #39 tdo_s = jtdo;
      #1  jtck = 1'b1;
      #40 jtck = 1'b0;
   endtask

   task automatic xfer(input logic [NCHAN-1:0] mask, input logic [95:0] data, input int nbits,
                       input bit do_upd, output logic [31:0] tdo_word);
      logic t;
      tdo_word = '0;
      jce = mask; jshift = 1'b0; jupdate = 1'b0;
      tck_pulse(t);
      jshift = 1'b1;
      for (int i = 0; i < nbits; i++) begin
         jtdi = data[i];
         tck_pulse(t);
         if (i < 32) tdo_word[i] = t;
      end
      jce = '0; jshift = 1'b0; jtdi = 1'b0;
      if (do_upd) begin
         jupdate = 1'b1;
         tck_pulse(t);
         jupdate = 1'b0;
      end
      tck_pulse(t);
   endtask

   task automatic run(input string tag, input logic [NCHAN-1:0] mask, input logic [95:0] data,
                      input int nbits, input bit do_upd);
      int            s0, ch;
      bit            ok;
      logic [31:0]   tw, rb;
      s0 = strobe_cnt;
      ch = mask[0] ? 0 : 1;
      rb = dbgreg_in[ch*DW +: DW];
      xfer(mask, data, nbits, do_upd, tw);
      ok = do_upd && (nbits == DW);
      if (ok) begin
         exp_out = data[DW-1:0];
         exp_sel = SW'(ch);
      end else if (do_upd) begin
         exp_err = 1'b1;
      end
      check({tag, ".strobes"}, 64'(strobe_cnt - s0), ok ? 64'd1 : 64'd0);
      check({tag, ".out"}, dbgreg_out, exp_out);
      check({tag, ".sel"}, dbgreg_sel, exp_sel);
      check({tag, ".err"}, err_len, exp_err);
      if (ok) check({tag, ".strobe_val"}, last_out, exp_out);
      if (nbits >= 32) check({tag, ".tdo"}, tw, exp_tdo(rb));
   endtask

   task automatic clear_err(input string tag);
      err_clr = 1'b1;
      #10 err_clr = 1'b0;
      #10;
      exp_err = 1'b0;
      check(tag, err_len, exp_err);
   endtask

   initial begin
      logic        t;
      int          s0;
      logic [95:0] d;

      #20;
      check("rst.out", dbgreg_out, 0);
      check("rst.sel", dbgreg_sel, 0);
      check("rst.strobe", dbgreg_strobe, 0);
      check("rst.err", err_len, 0);
      check("rst.tdo", jtdo, 0);
      rst = 1'b0;
      #100;

      dbgreg_in = {32'h0, $urandom};
      run("ch0", 2'b01, 96'hDEADBEEF, 32, 1'b1);

      dbgreg_in = {32'h12345678, $urandom};
      run("rb", 2'b10, 96'h0, 32, 1'b1);

      d = {$urandom, $urandom, $urandom};
      run("short31", 2'b01, d, 31, 1'b1);
      clear_err("short31.clr");

      d = {$urandom, $urandom, $urandom};
      run("long96", 2'b10, d, 96, 1'b1);
      clear_err("long96.clr");

      d = {$urandom, $urandom, $urandom};
      run("both", 2'b11, d, 32, 1'b1);

      s0 = strobe_cnt;
      jupdate = 1'b1; tck_pulse(t); jupdate = 1'b0; tck_pulse(t);
      check("nocap.strobes", 64'(strobe_cnt - s0), 0);
      check("nocap.err", err_len, exp_err);

      jce = 2'b01; tck_pulse(t);
      jshift = 1'b1;
      for (int i = 0; i < 10; i++) begin
         jtdi = 1'($urandom);
         tck_pulse(t);
      end
      jce = '0; jshift = 1'b0; jtdi = 1'b0;
      jrstn = 1'b0; #400; jrstn = 1'b1; #400;
      s0 = strobe_cnt;
      jupdate = 1'b1; tck_pulse(t); jupdate = 1'b0; tck_pulse(t);
      check("jrstn.strobes", 64'(strobe_cnt - s0), 0);
      check("jrstn.err", err_len, exp_err);
      run("a5", 2'b01, 96'hA5A5A5A5, 32, 1'b1);

      d = {$urandom, $urandom, $urandom};
      run("pre_rst", 2'b10, d, 20, 1'b1);
      jce = 2'b01; tck_pulse(t);
      jshift = 1'b1;
      for (int i = 0; i < 5; i++) begin
         jtdi = 1'($urandom);
         tck_pulse(t);
      end
      #3 rst = 1'b1;
      #1;
      check("arst.out", dbgreg_out, 0);
      check("arst.sel", dbgreg_sel, 0);
      check("arst.strobe", dbgreg_strobe, 0);
      check("arst.err", err_len, 0);
      check("arst.tdo", jtdo, 0);
      #6 rst = 1'b0;
      jce = '0; jshift = 1'b0; jtdi = 1'b0;
      exp_out = '0; exp_sel = '0; exp_err = 1'b0;
      #100;

      for (int n = 0; n < 100; n++) begin
         logic [NCHAN-1:0] m;
         m = 2'($urandom_range(1, 3));
         dbgreg_in = {$urandom, $urandom};
         d = {64'h0, $urandom};
         run("rnd", m, d, 32, 1'b1);
      end
      check("final.err", err_len, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/jtag_dbgreg_bridge.md
# jtag_dbgreg_bridge

Parametrised JTAG user-data-register bridge between the ECP5 JTAGG primitive and the SoC debug-register port. It replaces the ad-hoc in-top shift logic with a reusable block offering NCHAN user IR channels, configurable register width, a shift-length check and TDO readback. It sits in the top level, fed directly by JTAGG outputs, and drives `dbgreg_*` into `soc` in the `clk` domain (normally 48 MHz).

## Interface
- `DW`, 32: data-register width in bits (8..64).
- `NCHAN`, 2: number of user DR channels (1..4); channel i is driven by `jce[i]`.
- `SYNC_STAGES`, 3: synchroniser depth for all JTAG inputs (2..4).
- `SW = max(1, $clog2(NCHAN))`: derived channel-index width.

- `clk`  in  1  system clock; must be at least 8x the TCK frequency.
- `rst`  in  1  asynchronous, active-high reset.
- `jtck`, `jtdi`, `jshift`, `jupdate`, `jrstn`  in  1 each  raw JTAGG outputs.
- `jce`  in  NCHAN  per-channel capture/shift enables from JTAGG.
- `jtdo`  out  1  TDO toward JTAGG user-TDO input.
- `dbgreg_in`  in  NCHAN*DW  readback values; channel i occupies bits [i*DW +: DW].
- `dbgreg_out`  out  DW  last accepted DR value.
- `dbgreg_sel`  out  SW  channel of `dbgreg_out`.
- `dbgreg_strobe`  out  1  one-cycle pulse when `dbgreg_out`/`dbgreg_sel` are updated.
- `err_len`  out  1  sticky flag: an update arrived with a wrong shift count.
- `err_clr`  in  1  synchronous clear for `err_len`.

## Operation
- All JTAG inputs pass through SYNC_STAGES flops. `tck_rise` is asserted when the last stage is 1 and the previous value was 0; `tck_fall` is the reverse. Other inputs are sampled from the same synchroniser depth, so they are aligned with `jtck`.
- State is IDLE / SHIFT, tracked with `cur_chan` and `chan_valid`.
- Capture, on `tck_rise` with any `jce` bit set and `jshift`=0:
  - the lowest set `jce` index becomes `cur_chan` and `chan_valid`=1;
  - `shreg` is loaded from that channel's `dbgreg_in` slice;
  - `bitcnt` is cleared.
- Shift, on `tck_rise` with `jshift`=1 and `chan_valid`:
  - `shreg` shifts right with `jtdi` entering the MSB;
  - `bitcnt` increments, saturating at DW+1.
- TDO: `jtdo` is registered and updated on `tck_fall` to `shreg[0]`, so the value is stable before the next rising TCK.
- Update, on `tck_rise` with `jupdate`=1 and `chan_valid`:
  - if `bitcnt`==DW: `dbgreg_out`<=`shreg`, `dbgreg_sel`<=`cur_chan`, and `dbgreg_strobe` pulses;
  - otherwise outputs are unchanged, no strobe is issued, and `err_len`<=1;
  - in both cases `chan_valid`<=0 (return to IDLE).
- Shift or update with `chan_valid`=0 is ignored.
- A synchronised `jrstn`=0 clears `shreg`, `bitcnt`, `chan_valid`, `cur_chan` and `jtdo`. It does not alter `dbgreg_out`, `dbgreg_sel` or `err_len`.
- Simultaneous `err_clr` and a new length error: `err_len` stays 1 (set wins).

## Timing
- Reset values: all outputs 0, and all internal state including the synchroniser flops is 0.
- Edge-detect latency: a raw `jtck` edge produces `tck_rise` or `tck_fall` SYNC_STAGES or SYNC_STAGES+1 clk cycles later.
- Update latency: if `tck_rise` with a valid update occurs in cycle N, then `dbgreg_out` and `dbgreg_sel` are valid from cycle N+1, and `dbgreg_strobe`=1 in cycle N+1 only.
- `err_len` rises in cycle N+1 for a bad update; `err_clr` takes effect on the next edge.
- There is no backpressure. The consumer must take `dbgreg_out` on the strobe; the value holds until the next valid update.
- `rst` asserted mid-shift discards the transfer immediately.

## Configuration
- Macro `JTAG_DBGREG_READBACK_EN`.
- Defined: capture loads `dbgreg_in`, and `jtdo` follows `shreg[0]` as described above.
- Undefined:
  - capture loads all zeros;
  - `jtdo` is tied 0;
  - the `dbgreg_in` port remains present but is unused.
- The length check and the update path are identical in both cases.

## Structure
- Package `jtag_dbg_pkg` holds:
  - default constants `JTAG_DBG_DW`=32 and `JTAG_DBG_NCHAN`=2;
  - the `jtag_state_t` enum (IDLE, SHIFT);
  - a `first_set_index` function for `jce` priority encoding.
- Sub-module `jtag_tck_sync` holds the parametrised synchroniser chain for `jtck` plus the sideband inputs. It outputs the aligned signals together with `tck_rise` and `tck_fall`.

## Test plan
- DW=32, channel 0: capture, shift 0xDEADBEEF LSB-first, update -> one strobe with `dbgreg_out`=0xDEADBEEF and `dbgreg_sel`=0; `err_len`=0.
- Readback: `dbgreg_in` ch1=0x12345678, capture on `jce[1]`, shift 32 bits of 0 -> `jtdo` sequence equals 0x12345678 LSB-first, and the strobe gives `dbgreg_out`=0, `dbgreg_sel`=1. Repeat without the macro -> `jtdo` is always 0.
- Short shift of 31 bits then update -> no strobe, `dbgreg_out` keeps its previous value, `err_len`=1. Then `err_clr` -> `err_len`=0.
- `jce`=2'b11 at capture -> channel 0 is selected. Update with no prior capture -> no strobe, no error.
- `jrstn` pulsed low mid-shift after 10 bits, then a full 32-bit transfer of 0xA5A5A5A5 -> a single strobe with 0xA5A5A5A5. Async `rst` mid-shift -> all outputs 0 on the same cycle.
- TCK at exactly clk/8 with random data over 100 transfers across both channels -> every strobe matches the shifted word, and zero errors.
